// File: rtl/ln_lut_arbiter.sv
// Round-robin arbiter sharing one 1-cycle ln LUT among N_REQ requesters; optional LN_ARB_STATS_EN adds grant counters.
// Latency: accept in cycle t, LUT issue in t, result held in the requester's slot from t+2 (2 cycles).
// Backpressure: a requester is not granted while its slot is full and undrained or its own lookup is in flight.
module ln_lut_arbiter #(
    parameter int WIDTH = 32,
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_x,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       resp_valid,
    input  logic [N_REQ-1:0]       resp_ready,
    output logic [N_REQ*WIDTH-1:0] resp_ln,
    output logic                   lut_valid_in,
    output logic [WIDTH-1:0]       lut_x,
    input  logic                   lut_valid_out,
    input  logic [WIDTH-1:0]       lut_ln,
    output logic                   busy,
    output logic                   err,
    output logic [N_REQ*CNT_W-1:0] grant_cnt
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // architectural state
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             inflight_v_q, inflight_v_d;
    logic [PTR_W-1:0] inflight_id_q, inflight_id_d;
    logic [N_REQ-1:0] slot_full_q, slot_full_d;
    logic [WIDTH-1:0] slot_data_q [N_REQ];
    logic [WIDTH-1:0] slot_data_d [N_REQ];
    logic             err_q, err_d;

    // arbitration signals
    logic [N_REQ-1:0] inflight_oh;
    logic [N_REQ-1:0] elig;
    logic             gnt_vld;
    logic [PTR_W-1:0] gnt_id;
    logic [N_REQ-1:0] gnt_oh;
    logic [PTR_W-1:0] ptr_nxt;

    // decode the in-flight tag and work out who may be granted this cycle
    always_comb begin
        inflight_oh = '0;
        elig        = '0;
        for (int i = 0; i < N_REQ; i++) begin
            inflight_oh[i] = inflight_v_q && (int'(inflight_id_q) == i);
            // a full slot is only reusable if it is being drained this very cycle
            elig[i] = req_valid[i] && (!slot_full_q[i] || resp_ready[i]) && !inflight_oh[i];
        end
    end

    // first eligible index at or above ptr, wrapping around
    always_comb begin
        int               idx;
        int               nxt;
        logic [PTR_W-1:0] idx_w;
        idx     = 0;
        nxt     = 0;
        idx_w   = '0;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        gnt_oh  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            idx_w = idx[PTR_W-1:0];
            if (!gnt_vld && elig[idx_w]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx_w;
            end
        end
        if (gnt_vld) begin
            gnt_oh[gnt_id] = 1'b1;
        end
        nxt = int'(gnt_id) + 1;
        if (nxt >= N_REQ) begin
            nxt = 0;
        end
        ptr_nxt = nxt[PTR_W-1:0];
    end

    // LUT issue port: operand of the granted requester, zero when idle
    always_comb begin
        lut_valid_in = gnt_vld;
        lut_x        = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_oh[i]) begin
                lut_x = req_x[i*WIDTH +: WIDTH];
            end
        end
    end

    assign req_ready = gnt_oh;

    // next-state: pointer advance, in-flight tag, slot drain/fill, error flag
    always_comb begin
        ptr_d         = ptr_q;
        inflight_v_d  = gnt_vld;
        inflight_id_d = inflight_id_q;
        slot_full_d   = slot_full_q & ~resp_ready;
        slot_data_d   = slot_data_q;
        err_d         = err_q;
        if (gnt_vld) begin
            ptr_d         = ptr_nxt;
            inflight_id_d = gnt_id;
        end
        if (lut_valid_out) begin
            if (inflight_v_q) begin
                // a returning result wins over a same-cycle drain of its slot
                for (int i = 0; i < N_REQ; i++) begin
                    if (inflight_oh[i]) begin
                        slot_full_d[i] = 1'b1;
                        slot_data_d[i] = lut_ln;
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q         <= '0;
            inflight_v_q  <= 1'b0;
            inflight_id_q <= '0;
            slot_full_q   <= '0;
            err_q         <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                slot_data_q[i] <= '0;
            end
        end else begin
            ptr_q         <= ptr_d;
            inflight_v_q  <= inflight_v_d;
            inflight_id_q <= inflight_id_d;
            slot_full_q   <= slot_full_d;
            err_q         <= err_d;
            for (int i = 0; i < N_REQ; i++) begin
                slot_data_q[i] <= slot_data_d[i];
            end
        end
    end

    // pack the response slots onto the flat output bus
    always_comb begin
        resp_ln = '0;
        for (int i = 0; i < N_REQ; i++) begin
            resp_ln[i*WIDTH +: WIDTH] = slot_data_q[i];
        end
    end

    assign resp_valid = slot_full_q;
    assign busy       = inflight_v_q | (|slot_full_q);
    assign err        = err_q;

`ifdef LN_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [N_REQ];
    logic [CNT_W-1:0] cnt_d [N_REQ];

    // a grant is always an accept, so count grants; hold at all-ones
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_oh[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // pack the counters onto the flat output bus
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_ln_lut_arbiter.sv
// Directed bench for ln_lut_arbiter with a 1-cycle behavioural LUT stand-in.
// Latency: LUT result one cycle after issue, as the real fxlnLUT.
// Backpressure: driven directly through resp_ready per requester.
module tb_ln_lut_arbiter;

    localparam int W = 32;
    localparam int N = 4;
    localparam int C = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_x;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   resp_valid;
    logic [N-1:0]   resp_ready;
    logic [N*W-1:0] resp_ln;
    logic           lut_valid_in;
    logic [W-1:0]   lut_x;
    logic           lut_valid_out;
    logic [W-1:0]   lut_ln;
    logic           busy;
    logic           err;
    logic [N*C-1:0] grant_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic         lv_q = 1'b0;
    logic [W-1:0] lln_q = '0;
    logic         spur;

    logic [W-1:0] xs [N];
    logic [W-1:0] x1, x2;

    always #5 clk = ~clk;

    ln_lut_arbiter #(.WIDTH(W), .N_REQ(N), .CNT_W(C)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ln(resp_ln),
        .lut_valid_in(lut_valid_in), .lut_x(lut_x),
        .lut_valid_out(lut_valid_out), .lut_ln(lut_ln),
        .busy(busy), .err(err), .grant_cnt(grant_cnt)
    );

    // stand-in LUT: a fixed, easily hand-checked mapping, one cycle latency
    function automatic logic [W-1:0] lnm(input logic [W-1:0] x);
        return {x[15:0], x[31:16]} ^ 32'h0000_FFFF;
    endfunction

    always @(posedge clk) begin
        if (rst) lv_q <= 1'b0;
        else     lv_q <= lut_valid_in;
        lln_q <= lnm(lut_x);
    end

    assign lut_valid_out = lv_q | spur;
    assign lut_ln        = lln_q;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        req_x      = '0;
        resp_ready = '1;
        spur       = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] slot_ln(input int i);
        return resp_ln[i*W +: W];
    endfunction

    function automatic logic [31:0] cnt_of(input int i);
        return 32'(grant_cnt[i*C +: C]);
    endfunction

    function automatic logic [31:0] exp_cnt(input int v);
`ifdef LN_ARB_STATS_EN
        return 32'(v);
`else
        return 32'(v - v);
`endif
    endfunction

    initial begin
        rst = 1'b1; req_valid = '0; req_x = '0; resp_ready = '1; spur = 1'b0;
        xs[0] = 32'h0003_0000; xs[1] = 32'h0000_4000;
        xs[2] = 32'h0010_0000; xs[3] = 32'h0000_0100;
        x1 = 32'h1111_0000; x2 = 32'h2222_8000;

        // reset state
        do_reset();
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_rvalid", 32'(resp_valid), 32'h0);
        check("rst_ln", resp_ln[31:0] | resp_ln[63:32] | resp_ln[95:64] | resp_ln[127:96], 32'h0);
        check("rst_lutv", 32'(lut_valid_in), 32'h0);
        check("rst_lutx", lut_x, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_cnt", grant_cnt[31:0] | grant_cnt[63:32], 32'h0);

        // single lookup
        tick();
        req_valid = 4'b0001; req_x[31:0] = 32'h0000_8000;
        #1;
        check("single_rdy", 32'(req_ready), 32'h1);
        check("single_lutv", 32'(lut_valid_in), 32'h1);
        check("single_lutx", lut_x, 32'h0000_8000);
        tick();
        req_valid = '0;
        #1;
        check("single_c1_lutv", 32'(lut_valid_in), 32'h0);
        check("single_c1_busy", 32'(busy), 32'h1);
        check("single_c1_rvalid", 32'(resp_valid), 32'h0);
        tick();
        #1;
        check("single_c2_rvalid", 32'(resp_valid), 32'h1);
        check("single_c2_ln", slot_ln(0), 32'h8000_FFFF);
        check("single_c2_cnt", cnt_of(0), exp_cnt(1));
        tick();
        #1;
        check("single_c3_rvalid", 32'(resp_valid), 32'h0);
        check("single_c3_busy", 32'(busy), 32'h0);

        // round-robin fairness
        do_reset();
        req_valid = '1;
        req_x = {xs[3], xs[2], xs[1], xs[0]};
        for (int c = 0; c < 40; c++) begin
            #1;
            check("rr_rdy", 32'(req_ready), 32'(1 << (c % 4)));
            check("rr_lutx", lut_x, xs[c % 4]);
            if (c >= 2) begin
                check("rr_rvalid", 32'(resp_valid), 32'(1 << ((c - 2) % 4)));
                check("rr_ln", slot_ln((c - 2) % 4), lnm(xs[(c - 2) % 4]));
            end
            tick();
        end
        req_valid = '0;
        #1;
        for (int i = 0; i < N; i++) begin
            check("rr_cnt", cnt_of(i), exp_cnt(10));
        end

        // backpressure on requester 1
        do_reset();
        resp_ready = 4'b1101;
        req_valid  = 4'b0010;
        req_x[63:32] = x1;
        #1;
        check("bp_c0_rdy", 32'(req_ready), 32'h2);
        check("bp_c0_lutx", lut_x, x1);
        tick();
        req_x[63:32] = x2;
        #1;
        check("bp_c1_rdy", 32'(req_ready), 32'h0);
        tick();
        for (int c = 2; c < 10; c++) begin
            #1;
            check("bp_hold_rdy", 32'(req_ready), 32'h0);
            check("bp_hold_rvalid", 32'(resp_valid), 32'h2);
            check("bp_hold_ln", slot_ln(1), lnm(x1));
            tick();
        end
        resp_ready = '1;
        #1;
        check("bp_c10_rdy", 32'(req_ready), 32'h2);
        check("bp_c10_lutx", lut_x, x2);
        tick();
        req_valid = '0;
        #1;
        check("bp_c11_rvalid", 32'(resp_valid), 32'h0);
        tick();
        #1;
        check("bp_c12_rvalid", 32'(resp_valid), 32'h2);
        check("bp_c12_ln", slot_ln(1), lnm(x2));
        check("bp_c12_cnt", cnt_of(1), exp_cnt(2));

        // in-flight exclusion, requester 2 alone
        do_reset();
        req_valid = 4'b0100;
        req_x[95:64] = xs[2];
        for (int c = 0; c < 8; c++) begin
            #1;
            check("ifx_rdy", 32'(req_ready), (c % 2 == 0) ? 32'h4 : 32'h0);
            check("ifx_lutv", 32'(lut_valid_in), (c % 2 == 0) ? 32'h1 : 32'h0);
            tick();
        end
        req_valid = '0;

        // reset in the cycle after a grant
        do_reset();
        req_valid = 4'b0001;
        req_x[31:0] = xs[0];
        #1;
        check("rmf_rdy", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rmf_busy", 32'(busy), 32'h0);
        check("rmf_rvalid", 32'(resp_valid), 32'h0);
        check("rmf_err", 32'(err), 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            check("rmf_late_rvalid", 32'(resp_valid), 32'h0);
            check("rmf_late_busy", 32'(busy), 32'h0);
        end
        req_valid = '1;
        #1;
        check("rmf_ptr0", 32'(req_ready), 32'h1);
        req_valid = '0;
        tick();

        // spurious LUT output with nothing in flight
        do_reset();
        spur = 1'b1;
        #1;
        check("spur_c0_err", 32'(err), 32'h0);
        tick();
        spur = 1'b0;
        #1;
        check("spur_c1_err", 32'(err), 32'h1);
        check("spur_c1_rvalid", 32'(resp_valid), 32'h0);
        check("spur_c1_busy", 32'(busy), 32'h0);
        tick();
        tick();
        #1;
        check("spur_sticky", 32'(err), 32'h1);
        check("spur_late_rvalid", 32'(resp_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
